branch_dispatch_unit: RTL and testbench

//  Initiator/consumer side of the branch exec element handshake (inst_num 32..42).
//  - Accepts one decoded branch/jump op and latches its operands.
//  - Arms the element through its reset pin, then waits for `completed`.
//  - Commits the result: link register write and PC redirect to fetch.
//  - Sits between the issue stage and the register file / fetch PC logic.

---
 rtl/felis_branch_pkg.sv | 24 ++
 rtl/branch_link_decode.sv | 31 +++
 rtl/branch_dispatch_unit.sv | 137 +++++++++++++
 tb/tb_branch_dispatch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/felis_branch_pkg.sv
// Shared op codes, link register index and FSM state type for the branch dispatch path.
package felis_branch_pkg;

    localparam logic [5:0] OP_BEQ    = 6'd32;
    localparam logic [5:0] OP_BNE    = 6'd33;
    localparam logic [5:0] OP_BLEZ   = 6'd34;
    localparam logic [5:0] OP_BGTZ   = 6'd35;
    localparam logic [5:0] OP_BLTZ   = 6'd36;
    localparam logic [5:0] OP_BGEZAL = 6'd37;
    localparam logic [5:0] OP_BLTZAL = 6'd38;
    localparam logic [5:0] OP_J      = 6'd39;
    localparam logic [5:0] OP_JAL    = 6'd40;
    localparam logic [5:0] OP_JR     = 6'd41;
    localparam logic [5:0] OP_JALR   = 6'd42;

    localparam logic [4:0] LINK_REG  = 5'd31;

    typedef enum logic [1:0] {IDLE, ARM, WAIT, COMMIT} bdu_state_t;

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op >= OP_BEQ) && (op <= OP_JALR);
    endfunction

endpackage

// File: rtl/branch_link_decode.sv
// Decides whether an op writes a link register and which one.
module branch_link_decode
    import felis_branch_pkg::*;
(
    input  logic [5:0] inst_num,
    input  logic [4:0] rd,
    output logic       link_en,
    output logic [4:0] link_addr
);

    always_comb begin
        link_en   = 1'b0;
        link_addr = '0;
        case (inst_num)
            OP_BGEZAL, OP_BLTZAL, OP_JAL: begin
                link_en   = 1'b1;
                link_addr = LINK_REG;
            end
            OP_JALR: begin
                // rd=0 is the hardwired zero register, so no write is issued
                link_en   = (rd != 5'd0);
                link_addr = rd;
            end
            default: begin
                link_en   = 1'b0;
                link_addr = '0;
            end
        endcase
    end

endmodule

// File: rtl/branch_dispatch_unit.sv
// Issues one branch op to the exec element, waits for completion and commits
// the link write and PC redirect.
module branch_dispatch_unit
    import felis_branch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [5:0]       in_inst_num,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_rs,
    input  logic [31:0]      in_rt,
    input  logic [31:0]      in_const16_x,
    input  logic [25:0]      in_addr26,
    input  logic             flush,
    output logic             ee_reset,
    output logic [31:0]      ee_pc,
    output logic [5:0]       ee_inst_num,
    output logic [31:0]      ee_const16_x,
    output logic [25:0]      ee_addr26,
    output logic [31:0]      ee_rs,
    output logic [31:0]      ee_rt,
    input  logic             ee_completed,
    input  logic [31:0]      ee_reg_out,
    input  logic [31:0]      ee_pc_out,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             err_timeout,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    bdu_state_t        state, state_next;
    logic [WCNT_W-1:0] wait_cnt;
    logic [4:0]        rd_q;
    logic              link_en;
    logic [4:0]        link_addr;
    logic              accept, commit_go, timeout_hit;

    branch_link_decode u_link_decode (
        .inst_num  (ee_inst_num),
        .rd        (rd_q),
        .link_en   (link_en),
        .link_addr (link_addr)
    );

    assign accept      = (state == IDLE) && in_valid && !flush;
    assign commit_go   = (state == WAIT) && ee_completed && !flush;
    assign timeout_hit = (state == WAIT) && !ee_completed && !flush &&
                         (wait_cnt == WCNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ARM;
            ARM:     state_next = flush ? IDLE : WAIT;
            WAIT: begin
                if (flush)            state_next = IDLE;
                else if (ee_completed) state_next = COMMIT;
                else if (timeout_hit)  state_next = IDLE;
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        ee_reset = reset | (state == ARM);
    end

    // Strobes are built at the WAIT->COMMIT edge so they are registered during COMMIT
    always_ff @(posedge clk) begin
        if (reset) begin
            ee_pc          <= '0;
            ee_inst_num    <= '0;
            ee_const16_x   <= '0;
            ee_addr26      <= '0;
            ee_rs          <= '0;
            ee_rt          <= '0;
            rd_q           <= '0;
            wait_cnt       <= '0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            err_timeout    <= 1'b0;
            branch_cnt     <= '0;
            taken_cnt      <= '0;
        end else begin
            rf_we          <= 1'b0;
            redirect_valid <= 1'b0;
            err_timeout    <= timeout_hit;
            if (accept) begin
                ee_pc        <= in_pc;
                ee_inst_num  <= in_inst_num;
                ee_const16_x <= in_const16_x;
                ee_addr26    <= in_addr26;
                ee_rs        <= in_rs;
                ee_rt        <= in_rt;
                rd_q         <= in_rd;
            end
            if (state == ARM)
                wait_cnt <= '0;
            else if (state == WAIT && !ee_completed)
                wait_cnt <= wait_cnt + WCNT_W'(1);
            if (commit_go) begin
                rf_we          <= link_en;
                rf_waddr       <= link_addr;
                rf_wdata       <= ee_reg_out;
                redirect_pc    <= ee_pc_out;
                redirect_valid <= is_branch_op(ee_inst_num) && (ee_pc_out != ee_pc + 32'd4);
            end
            if (state == COMMIT && !flush) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
                if (redirect_valid) taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_dispatch_unit.sv
// Directed bench for branch_dispatch_unit with a behavioural exec element stub.
module tb_branch_dispatch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [5:0]  in_inst_num;
    logic [4:0]  in_rd;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [31:0] in_const16_x;
    logic [25:0] in_addr26;
    logic        flush;
    logic        ee_reset;
    logic [31:0] ee_pc;
    logic [5:0]  ee_inst_num;
    logic [31:0] ee_const16_x;
    logic [25:0] ee_addr26;
    logic [31:0] ee_rs;
    logic [31:0] ee_rt;
    logic        ee_completed;
    logic [31:0] ee_reg_out;
    logic [31:0] ee_pc_out;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        err_timeout;
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic        stub_en;
    logic [31:0] stub_reg_out;
    logic [31:0] stub_pc_out;

    branch_dispatch_unit #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst_num(in_inst_num), .in_rd(in_rd), .in_rs(in_rs),
        .in_rt(in_rt), .in_const16_x(in_const16_x), .in_addr26(in_addr26),
        .flush(flush), .ee_reset(ee_reset), .ee_pc(ee_pc), .ee_inst_num(ee_inst_num),
        .ee_const16_x(ee_const16_x), .ee_addr26(ee_addr26), .ee_rs(ee_rs), .ee_rt(ee_rt),
        .ee_completed(ee_completed), .ee_reg_out(ee_reg_out), .ee_pc_out(ee_pc_out),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .err_timeout(err_timeout), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    // Element stub: cleared while armed, completes one cycle after release
    always @(posedge clk) begin
        if (ee_reset)     ee_completed <= 1'b0;
        else if (stub_en) ee_completed <= 1'b1;
    end
    assign ee_reg_out = stub_reg_out;
    assign ee_pc_out  = stub_pc_out;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one op for a single cycle; returns at the negedge inside ARM
    task automatic issue(input logic [5:0] op, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [25:0] a26);
        in_inst_num  = op;
        in_pc        = pc;
        in_rd        = rd;
        in_rs        = rs;
        in_rt        = rt;
        in_const16_x = imm;
        in_addr26    = a26;
        in_valid     = 1'b1;
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; stub_en = 1'b1;
        in_pc = '0; in_inst_num = '0; in_rd = '0; in_rs = '0; in_rt = '0;
        in_const16_x = '0; in_addr26 = '0; stub_reg_out = '0; stub_pc_out = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ee_reset", 32'(ee_reset), 32'd1);
        check("reset_rf_we", 32'(rf_we), 32'd0);
        check("reset_redirect_pc", redirect_pc, 32'd0);
        check("reset_branch_cnt", branch_cnt, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_ee_reset", 32'(ee_reset), 32'd0);

        // 1: BEQ taken
        stub_reg_out = 32'h104; stub_pc_out = 32'h110;
        issue(OP_BEQ_C(), 32'h100, 5'd0, 32'd5, 32'd5, 32'd4, 26'd0);
        check("beq_arm_ee_reset", 32'(ee_reset), 32'd1);
        check("beq_arm_in_ready", 32'(in_ready), 32'd0);
        check("beq_ee_pc", ee_pc, 32'h100);
        check("beq_ee_const", ee_const16_x, 32'd4);
        repeat (3) @(negedge clk);
        check("beq_rf_we", 32'(rf_we), 32'd0);
        check("beq_redirect_valid", 32'(redirect_valid), 32'd1);
        check("beq_redirect_pc", redirect_pc, 32'h110);
        check("beq_commit_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("beq_redirect_drop", 32'(redirect_valid), 32'd0);
        check("beq_in_ready_after", 32'(in_ready), 32'd1);
        check("beq_branch_cnt", branch_cnt, 32'd1);
        check("beq_taken_cnt", taken_cnt, 32'd1);

        // 2: BGTZ not taken, from fresh counters
        pulse_reset();
        stub_reg_out = 32'h204; stub_pc_out = 32'h204;
        issue(6'd35, 32'h200, 5'd0, 32'd0, 32'd0, 32'd8, 26'd0);
        repeat (3) @(negedge clk);
        check("bgtz_rf_we", 32'(rf_we), 32'd0);
        check("bgtz_redirect_valid", 32'(redirect_valid), 32'd0);
        @(negedge clk);
        check("bgtz_branch_cnt", branch_cnt, 32'd1);
        check("bgtz_taken_cnt", taken_cnt, 32'd0);

        // 3: JAL links to r31
        stub_reg_out = 32'h3000_0044; stub_pc_out = 32'h3000_0040;
        issue(6'd40, 32'h3000_0040, 5'd0, 32'd0, 32'd0, 32'd0, 26'h10);
        check("jal_ee_addr26", 32'(ee_addr26), 32'h10);
        repeat (3) @(negedge clk);
        check("jal_rf_we", 32'(rf_we), 32'd1);
        check("jal_rf_waddr", 32'(rf_waddr), 32'd31);
        check("jal_rf_wdata", rf_wdata, 32'h3000_0044);
        check("jal_redirect_valid", 32'(redirect_valid), 32'd1);
        check("jal_redirect_pc", redirect_pc, 32'h3000_0040);
        @(negedge clk);
        check("jal_rf_we_drop", 32'(rf_we), 32'd0);
        check("jal_taken_cnt", taken_cnt, 32'd1);

        // 4: JALR rd=0 suppresses the write
        stub_reg_out = 32'h404; stub_pc_out = 32'h8000;
        issue(6'd42, 32'h400, 5'd0, 32'h8000, 32'd0, 32'd0, 26'd0);
        check("jalr0_ee_rs", ee_rs, 32'h8000);
        repeat (3) @(negedge clk);
        check("jalr0_rf_we", 32'(rf_we), 32'd0);
        check("jalr0_redirect_pc", redirect_pc, 32'h8000);
        @(negedge clk);

        // 5: JALR rd=7
        stub_reg_out = 32'h504; stub_pc_out = 32'h8000;
        issue(6'd42, 32'h500, 5'd7, 32'h8000, 32'd0, 32'd0, 26'd0);
        repeat (3) @(negedge clk);
        check("jalr7_rf_we", 32'(rf_we), 32'd1);
        check("jalr7_rf_waddr", 32'(rf_waddr), 32'd7);
        check("jalr7_rf_wdata", rf_wdata, 32'h504);
        check("jalr7_redirect_pc", redirect_pc, 32'h8000);
        @(negedge clk);
        check("jalr7_branch_cnt", branch_cnt, 32'd4);
        check("jalr7_taken_cnt", taken_cnt, 32'd3);

        // Out-of-range op commits with no result
        stub_reg_out = 32'h0; stub_pc_out = 32'h1234;
        issue(6'd50, 32'h600, 5'd3, 32'd0, 32'd0, 32'd0, 26'd0);
        repeat (3) @(negedge clk);
        check("badop_rf_we", 32'(rf_we), 32'd0);
        check("badop_redirect_valid", 32'(redirect_valid), 32'd0);
        @(negedge clk);
        check("badop_branch_cnt", branch_cnt, 32'd5);
        check("badop_taken_cnt", taken_cnt, 32'd3);

        // pc+4 wraps to zero: fall-through is not a redirect
        stub_reg_out = 32'h0; stub_pc_out = 32'h0;
        issue(6'd33, 32'hFFFF_FFFC, 5'd0, 32'd1, 32'd1, 32'd4, 26'd0);
        repeat (3) @(negedge clk);
        check("wrap_redirect_valid", 32'(redirect_valid), 32'd0);
        @(negedge clk);

        // 6: element never completes
        stub_en = 1'b0;
        issue(6'd32, 32'h700, 5'd0, 32'd0, 32'd0, 32'd0, 26'd0);
        repeat (16) @(negedge clk);
        check("to_not_yet", 32'(err_timeout), 32'd0);
        check("to_still_busy", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("to_pulse", 32'(err_timeout), 32'd1);
        check("to_in_ready", 32'(in_ready), 32'd1);
        check("to_rf_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        check("to_pulse_end", 32'(err_timeout), 32'd0);
        check("to_branch_cnt", branch_cnt, 32'd6);
        stub_en = 1'b1;

        // 7: flush coincides with completion
        stub_reg_out = 32'h804; stub_pc_out = 32'h900;
        issue(6'd40, 32'h800, 5'd0, 32'd0, 32'd0, 32'd0, 26'd0);
        repeat (2) @(negedge clk);
        check("fl_completed_seen", 32'(ee_completed), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_rf_we", 32'(rf_we), 32'd0);
        check("fl_redirect_valid", 32'(redirect_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("fl_branch_cnt", branch_cnt, 32'd6);
        check("fl_taken_cnt", taken_cnt, 32'd3);

        // flush in IDLE blocks acceptance
        in_inst_num = 6'd32; in_pc = 32'hA00; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_in_ready", 32'(in_ready), 32'd1);
        check("idle_flush_no_arm", 32'(ee_reset), 32'd0);

        // 8: reset while waiting
        issue(6'd40, 32'hB00, 5'd0, 32'd0, 32'd0, 32'd0, 26'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ee_reset", 32'(ee_reset), 32'd1);
        check("rst_ee_pc", ee_pc, 32'd0);
        check("rst_branch_cnt", branch_cnt, 32'd0);
        check("rst_taken_cnt", taken_cnt, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_no_commit", 32'(rf_we), 32'd0);
        check("rst_no_redirect", 32'(redirect_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [5:0] OP_BEQ_C();
        return 6'd32;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
